// File: rtl/ub_read_sequencer.sv
// Streams rows out of the unified buffer (port 0) for a {start address, row count} command.
// A credit check on in-flight reads keeps the output FIFO from overflowing when downstream stalls.
module ub_read_sequencer #(
    parameter int MATRIX_WIDTH      = 14,
    parameter int BUFFER_ADDR_WIDTH = 24,
    parameter int LENGTH_WIDTH      = 16,
    parameter int READ_LATENCY      = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [BUFFER_ADDR_WIDTH-1:0]  cmd_address,
    input  logic [LENGTH_WIDTH-1:0]       cmd_length,
    output logic [BUFFER_ADDR_WIDTH-1:0]  ub_address,
    output logic                          ub_en,
    input  logic [MATRIX_WIDTH*8-1:0]     ub_read_port,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [MATRIX_WIDTH*8-1:0]     out_data,
    output logic                          out_last,
    output logic                          busy
);

    localparam int FIFO_DEPTH = READ_LATENCY + 2;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int SUM_W      = CNT_W + 1;
    localparam int DATA_W     = MATRIX_WIDTH * 8;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]                   r_state;
    logic [BUFFER_ADDR_WIDTH-1:0] r_addr;
    logic [LENGTH_WIDTH-1:0]      r_remaining;
    logic [READ_LATENCY-1:0]      r_pipe_valid;
    logic [READ_LATENCY-1:0]      r_pipe_last;
    logic [DATA_W-1:0]            r_fifo_data [FIFO_DEPTH];
    logic                         r_fifo_last [FIFO_DEPTH];
    logic [PTR_W-1:0]             r_wr_ptr;
    logic [PTR_W-1:0]             r_rd_ptr;
    logic [CNT_W-1:0]             r_count;

    logic [CNT_W-1:0]             w_inflight;
    logic                         w_credit_ok;
    logic                         w_issue;
    logic                         w_last_issue;
    logic                         w_push;
    logic                         w_pop;
    logic                         w_fifo_nonempty;
    logic                         w_head_last;
    logic                         w_cmd_accept;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        w_inflight = '0;
        for (int unsigned i = 0; i < READ_LATENCY; i++) begin
            w_inflight = w_inflight + CNT_W'(r_pipe_valid[i]);
        end
    end

    // Every in-flight read is guaranteed a FIFO slot, so a stalled consumer can never cause overflow.
    assign w_credit_ok     = (SUM_W'(w_inflight) + SUM_W'(r_count)) < SUM_W'(FIFO_DEPTH);
    assign w_issue         = (r_state == S_ISSUE) && enable && (r_remaining != '0) && w_credit_ok;
    assign w_last_issue    = w_issue && (r_remaining == LENGTH_WIDTH'(1));
    assign w_push          = enable && r_pipe_valid[READ_LATENCY-1];
    assign w_fifo_nonempty = (r_count != '0);
    assign w_pop           = w_fifo_nonempty && out_ready;
    assign w_head_last     = r_fifo_last[r_rd_ptr];
    assign w_cmd_accept    = (r_state == S_IDLE) && cmd_valid;

    assign cmd_ready  = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign ub_en      = w_issue;
    assign ub_address = r_addr;
    assign out_valid  = w_fifo_nonempty;
    assign out_data   = w_fifo_nonempty ? r_fifo_data[r_rd_ptr] : '0;
    assign out_last   = w_fifo_nonempty ? w_head_last : 1'b0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_cmd_accept && (cmd_length != '0)) begin
                        r_addr      <= cmd_address;
                        r_remaining <= cmd_length;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_issue) begin
                        r_addr      <= r_addr + BUFFER_ADDR_WIDTH'(1);
                        r_remaining <= r_remaining - LENGTH_WIDTH'(1);
                        if (w_last_issue) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_pop && w_head_last) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pipe_valid <= '0;
            r_pipe_last  <= '0;
        end else if (enable) begin
            r_pipe_valid[0] <= w_issue;
            r_pipe_last[0]  <= w_last_issue;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                r_pipe_valid[i] <= r_pipe_valid[i-1];
                r_pipe_last[i]  <= r_pipe_last[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: outputs are masked by the (reset) occupancy count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= ub_read_port;
            r_fifo_last[r_wr_ptr] <= r_pipe_last[READ_LATENCY-1];
        end
    end

endmodule
